// File: rtl/uart_apb_arb_pkg.sv
// Shared types and defaults for the UART APB arbiter.
// Holds the sequencer state enum and the latched transfer record.
package uart_apb_arb_pkg;

  localparam int ADDR_W_DEF  = 5;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } arb_state_e;

  typedef struct packed {
    logic                  wr;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } xfer_t;

endpackage

// File: rtl/uart_apb_rr_pick.sv
// Two-way round-robin selector.
// ptr names the favoured port when both request.
module uart_apb_rr_pick (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       idx,
  output logic       valid
);

  always_comb begin
    valid = |req;
    idx   = 1'b0;
    unique case (req)
      2'b11:   idx = ptr;
      2'b10:   idx = 1'b1;
      default: idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/uart_apb_arb.sv
// Round-robin APB master sharing one UART slave port
// between two request-until-done clients.
module uart_apb_arb
  import uart_apb_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  localparam int CNT_W = $clog2(TIMEOUT);

  arb_state_e        state_q, state_d;
  xfer_t             xfer_q, xfer_d;
  logic              gnt_q, gnt_d;
  logic              ptr_q, ptr_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic pick_idx;
  logic pick_valid;

  uart_apb_rr_pick u_pick (
    .req   ({req1, req0}),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    xfer_d  = xfer_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d        = pick_idx;
          ptr_d        = ~pick_idx;
          xfer_d.wr    = pick_idx ? wr1 : wr0;
          xfer_d.addr  = ADDR_W_DEF'(pick_idx ? addr1 : addr0);
          xfer_d.wdata = DATA_W_DEF'(pick_idx ? wdata1 : wdata0);
          cnt_d        = '0;
          state_d      = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        err_d   = 1'b0;
        rdata_d = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          rdata_d = xfer_q.wr ? '0 : PRDATA;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= IDLE;
      xfer_q  <= '0;
      gnt_q   <= 1'b0;
      ptr_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      xfer_q  <= xfer_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Address/data hold across idle; only strobes drop.
  always_comb begin
    PSEL    = (state_q == SETUP) || (state_q == ACCESS);
    PENABLE = (state_q == ACCESS);
    PWRITE  = xfer_q.wr;
    PADDR   = ADDR_W'(xfer_q.addr);
    PWDATA  = DATA_W'(xfer_q.wdata);
    done0   = (state_q == DONE) && !gnt_q;
    done1   = (state_q == DONE) && gnt_q;
    err0    = done0 && err_q;
    err1    = done1 && err_q;
    rdata   = (state_q == DONE) ? rdata_q : '0;
  end

endmodule

// File: tb/tb_uart_apb_arb.sv
// Self-checking bench for uart_apb_arb.
// Behavioural APB slave with wait states and a stuck mode.
module tb_uart_apb_arb;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          req0, req1, wr0, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          done0, done1, err0, err1;
  logic [DW-1:0] rdata;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY;

  always #5 PCLK = ~PCLK;

  uart_apb_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .rdata(rdata),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  logic          stall = 1'b0;
  int            wait_cfg = 0;
  logic [DW-1:0] s_rdata = '0;
  int            wcnt = 0;
  int            we_cnt = 0;
  logic [AW-1:0] last_waddr = '0;
  logic [DW-1:0] last_wdata = '0;

  assign PREADY = PSEL && PENABLE && !stall && (wcnt >= wait_cfg);
  assign PRDATA = s_rdata;

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE) begin
      we_cnt     <= we_cnt + 1;
      last_waddr <= PADDR;
      last_wdata <= PWDATA;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic prev_psel = 1'b0;
  int   low_run = 100;

  always @(negedge PCLK) begin
    if (PSEL || PENABLE) begin
      n_checks++;
      if (PENABLE && !PSEL) begin
        n_fail++;
        $display("FAIL penable_wo_psel: got 1 expected 0");
      end
      if (PENABLE && !prev_psel) begin
        n_fail++;
        $display("FAIL penable_first_psel: got 1 expected 0");
      end
      if (PSEL && !prev_psel && low_run < 2) begin
        n_fail++;
        $display("FAIL psel_gap: got %0d expected >=2", low_run);
      end
    end
    if (done0 || done1) begin
      n_checks++;
      if (done0 && done1) begin
        n_fail++;
        $display("FAIL done_onehot: got 11 expected one-hot");
      end
    end
    low_run   = PSEL ? 0 : low_run + 1;
    prev_psel = PSEL;
  end

  typedef struct {
    string         name;
    logic          r0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    int            wt;
    logic          st;
    logic [DW-1:0] srd;
    logic          port;
    logic          err;
    logic [DW-1:0] rd;
    int            lat;
    int            pen;
  } vec_t;

  vec_t vecs[7];

  task automatic drop_reqs();
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic do_reset();
    PRESET = 1'b1;
    drop_reqs();
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
  endtask

  task automatic await_done(input int budget, output bit got,
                            output logic port, output int lat);
    got  = 1'b0;
    port = 1'b0;
    lat  = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge PCLK);
      if (done0 || done1) begin
        got  = 1'b1;
        port = done1;
        lat  = k;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int            pen;
    int            lat;
    bit            got;
    bit            leak;
    logic [3:0]    flags;
    logic [DW-1:0] rds;
    logic          ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    pen = 0; lat = 0; got = 0; leak = 0;
    flags = '0; rds = '0;
    ew = v.port ? v.w1 : v.w0;
    ea = v.port ? v.a1 : v.a0;
    ed = v.port ? v.d1 : v.d0;
    stall = v.st; wait_cfg = v.wt; s_rdata = v.srd;
    req0 = v.r0; wr0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; wr1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge PCLK);
      if (k == 1)
        check({v.name, "/setup"},
              {PSEL, PENABLE, PWRITE, PADDR, PWDATA},
              {1'b1, 1'b0, ew, ea, ed});
      if (PENABLE) pen++;
      if (done0 || done1) begin
        got   = 1'b1;
        lat   = k;
        flags = {done0, done1, err0, err1};
        rds   = rdata;
        break;
      end
      if (rdata != '0) leak = 1'b1;
    end
    drop_reqs();
    check({v.name, "/done_seen"}, 64'(got), 64'd1);
    check({v.name, "/flags"}, 64'(flags),
          64'({~v.port, v.port, v.err & ~v.port, v.err & v.port}));
    check({v.name, "/rdata"}, 64'(rds), 64'(v.rd));
    check({v.name, "/latency"}, 64'(lat), 64'(v.lat));
    check({v.name, "/penable_cycles"}, 64'(pen), 64'(v.pen));
    check({v.name, "/rdata_leak"}, 64'(leak), 64'd0);
    repeat (2) @(negedge PCLK);
  endtask

  initial begin
    bit            got;
    logic          port;
    int            lat;
    int            we0;
    int            dn;
    int            rises;
    logic          pp;
    logic          ports[4];
    int            lats[4];
    int            nd;

    PRESET = 1'b1;
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    vecs[0] = '{"wr0", 1, 1, 5'h0C, 32'h83, 0, 0, 5'h00, 32'h0,
                0, 0, 32'hFFFF_0001, 0, 0, 32'h0, 3, 1};
    vecs[1] = '{"rd1", 0, 0, 5'h00, 32'h0, 1, 0, 5'h14, 32'h0,
                0, 0, 32'h60, 1, 0, 32'h60, 3, 1};
    vecs[2] = '{"rd0_wait2", 1, 0, 5'h04, 32'h0, 0, 0, 5'h00, 32'h0,
                2, 0, 32'hA5A5_5A5A, 0, 0, 32'hA5A5_5A5A, 5, 3};
    vecs[3] = '{"both_ptr1", 1, 0, 5'h08, 32'h0, 1, 1, 5'h1C,
                32'hDEAD_BEEF, 1, 0, 32'h1111, 1, 0, 32'h0, 4, 2};
    vecs[4] = '{"both_ptr0", 1, 0, 5'h08, 32'h0, 1, 1, 5'h1C,
                32'hDEAD_BEEF, 0, 0, 32'h1234, 0, 0, 32'h1234, 3, 1};
    vecs[5] = '{"timeout1", 0, 0, 5'h00, 32'h0, 1, 0, 5'h10, 32'h0,
                0, 1, 32'hCAFE, 1, 1, 32'h0, 18, 16};
    vecs[6] = '{"timeout0", 1, 1, 5'h18, 32'h55, 0, 0, 5'h00, 32'h0,
                0, 1, 32'hBEEF, 0, 1, 32'h0, 18, 16};

    repeat (3) @(negedge PCLK);
    check("reset_ctrl",
          {done0, done1, err0, err1, PSEL, PENABLE, PWRITE}, 64'd0);
    check("reset_data", {PADDR, PWDATA}, 64'd0);
    check("reset_rdata", 64'(rdata), 64'd0);
    PRESET = 1'b0;
    @(negedge PCLK);

    we0 = we_cnt;
    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
      if (i == 0) begin
        check("wr0/we_pulses", 64'(we_cnt - we0), 64'd1);
        check("wr0/slave_write", {last_waddr, last_wdata},
              {5'h0C, 32'h83});
      end
    end
    check("table/we_pulses", 64'(we_cnt - we0), 64'd2);
    check("table/last_write", {last_waddr, last_wdata},
          {5'h1C, 32'hDEAD_BEEF});

    // Both requesters held high from reset: strict alternation.
    do_reset();
    stall = 0; wait_cfg = 0; s_rdata = 32'h7;
    wr0 = 0; wr1 = 0; addr0 = 5'h01; addr1 = 5'h02;
    req0 = 1; req1 = 1;
    nd = 0;
    for (int k = 1; k <= 30 && nd < 4; k++) begin
      @(negedge PCLK);
      if (done0 || done1) begin
        ports[nd] = done1;
        lats[nd]  = k;
        nd++;
      end
    end
    drop_reqs();
    check("alt/count", 64'(nd), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < nd) begin
        check($sformatf("alt/port%0d", i), 64'(ports[i]), 64'(i % 2));
        check($sformatf("alt/lat%0d", i), 64'(lats[i]),
              64'(3 + 4 * i));
      end
    end
    repeat (2) @(negedge PCLK);

    // Reset while a port-1 read is stuck in ACCESS.
    stall = 1; wr1 = 0; addr1 = 5'h14; req1 = 1;
    repeat (2) @(negedge PCLK);
    check("rst1/in_access", {PSEL, PENABLE}, 64'b11);
    PRESET = 1'b1;
    @(negedge PCLK);
    check("rst1/outputs", {PSEL, PENABLE, done0, done1, err0, err1,
          PWRITE, PADDR}, 64'd0);
    check("rst1/data", {rdata, PWDATA}, 64'd0);
    PRESET = 1'b0; drop_reqs(); stall = 0;
    dn = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge PCLK);
      if (done0 || done1) dn++;
    end
    check("rst1/no_done", 64'(dn), 64'd0);
    req0 = 1; req1 = 1;
    await_done(10, got, port, lat);
    drop_reqs();
    check("rst1/ptr_port", {got, port}, 2'b10);
    repeat (2) @(negedge PCLK);

    // Reset during a port-0 transfer must clear the pointer.
    stall = 1; req0 = 1;
    repeat (2) @(negedge PCLK);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0; drop_reqs(); stall = 0;
    repeat (2) @(negedge PCLK);
    req0 = 1; req1 = 1;
    await_done(10, got, port, lat);
    drop_reqs();
    check("rst0/ptr_port", {got, port}, 2'b10);
    repeat (2) @(negedge PCLK);

    // req0 withdrawn in SETUP: one completion, no reissue.
    we0 = we_cnt;
    wr0 = 1; addr0 = 5'h0A; wdata0 = 32'h77; req0 = 1;
    dn = 0; rises = 0; pp = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge PCLK);
      if (k == 1) req0 = 1'b0;
      if (done0) dn++;
      if (PSEL && !pp) rises++;
      pp = PSEL;
    end
    check("drop/done_count", 64'(dn), 64'd1);
    check("drop/psel_rises", 64'(rises), 64'd1);
    check("drop/we_pulses", 64'(we_cnt - we0), 64'd1);
    check("drop/slave_write", {last_waddr, last_wdata},
          {5'h0A, 32'h77});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_apb_arb.md
# uart_apb_arb

Two-port round-robin arbiter and APB master sequencer that shares the UART's APB slave port between two requesters, for example the CPU bridge and the DMA/test engine. Each requester presents a simple request-until-done transfer. The block serialises these transfers into compliant APB SETUP/ACCESS sequences, waits for PREADY, and returns read data or a timeout error to the granted requester.

## Interface
- ADDR_W, 5: APB address width.
- DATA_W, 32: APB data width.
- TIMEOUT, 16: maximum number of ACCESS cycles to wait for PREADY before aborting (≥2).
- PCLK  input  1  sole clock; all logic is on its rising edge.
- PRESET  input  1  synchronous, active-high reset.
- req0, req1  input  1  transfer request; held high until the matching done.
- wr0, wr1  input  1  1 = write, 0 = read.
- addr0, addr1  input  ADDR_W  register address.
- wdata0, wdata1  input  DATA_W  write data.
- done0, done1  output  1  one-cycle completion pulse.
- err0, err1  output  1  qualifies done: 1 = timed out.
- rdata  output  DATA_W  read data; valid only in the done cycle.
- PSEL, PENABLE, PWRITE  output  1  APB control.
- PADDR  output  ADDR_W  APB address.
- PWDATA  output  DATA_W  APB write data.
- PRDATA  input  DATA_W  APB read data.
- PREADY  input  1  APB ready.

## Operation
- Reset values: every output is 0, state is IDLE, priority pointer is 0, timeout counter is 0.
- States: IDLE, SETUP, ACCESS, DONE (state enum in package).
- IDLE: if any req is high, pick a winner, latch its wr/addr/wdata and the grant index, then go to SETUP. Otherwise stay in IDLE.
- SETUP: PSEL=1, PENABLE=0, with PADDR/PWRITE/PWDATA driven from the latched values. Always go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1, address/data stable.
  - PREADY sampled 1: capture PRDATA (reads) and go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without PREADY, go to DONE with the error flag set.
- DONE: PSEL=0 and PENABLE=0. Pulse done of the granted port for one cycle.
  - err is asserted if the transfer timed out.
  - rdata carries captured PRDATA for a successful read; it is 0 for writes and for timeouts.
  - Always go to IDLE.
- Round-robin: when both reqs are high in IDLE, the port selected by the pointer wins. After every grant the pointer is set to the other port.
- Arbitration happens only in IDLE. A req that drops mid-transfer is ignored: the transfer completes and done still pulses.
- A req still high in the cycle after its done is treated as a new request.
- PADDR/PWRITE/PWDATA hold their last values while idle. Only PSEL and PENABLE return to 0.

## Timing
- Requests are sampled at the edge ending an IDLE cycle, followed by:
  - SETUP in the next cycle;
  - ACCESS in the cycle after SETUP;
  - DONE in the cycle after PREADY is sampled high.
- Zero-wait slave: done pulses 3 cycles after the request edge; the minimum transfer occupancy is 4 cycles including IDLE.
- PENABLE is never high without PSEL. PENABLE is never high in the first PSEL cycle.
- PSEL deasserts for at least 2 cycles (DONE, IDLE) between transfers. This lets the UART slave's FSM return to IDLE.
- Timeout: PENABLE is high for exactly TIMEOUT cycles, then done+err pulses.
- PRESET asserted in any state: in the following cycle all outputs are 0 and the state is IDLE. Any in-flight transfer is dropped with no done pulse.

## Structure
- Package uart_apb_arb_pkg holds:
  - the ARB_STATE enum (IDLE, SETUP, ACCESS, DONE);
  - default ADDR_W/DATA_W/TIMEOUT constants;
  - a transfer struct {wr, addr, wdata} used for the latch.
- Sub-module uart_apb_rr_pick: combinational two-way round-robin selector. Inputs are req[1:0] and the pointer; outputs are a grant index and valid. The pointer register stays in the top level.

## Test plan
- Reset, then req0 write with addr=5'h0C, wdata=32'h83 against the UART APB slave → PSEL for 1 SETUP cycle, then PENABLE held until PREADY. The UART we_o pulses once, then done0=1, err0=0, and the pointer moves to 1.
- req1 read with addr=5'h14, slave returns 32'h60 → PWRITE=0, done1=1, rdata=32'h60 in the done cycle only.
- req0 and req1 both high from reset → port 0 is served first, then port 1, then port 0 again while both stay high. Grants strictly alternate.
- Stub slave with PREADY tied 0 and TIMEOUT=16 → PENABLE high for 16 cycles, then done0=1, err0=1, rdata=0, and PSEL drops.
- PRESET pulsed during ACCESS of a req1 transfer → next cycle PSEL=0, PENABLE=0, no done1 pulse, and the pointer resets to 0.
- req0 dropped during SETUP → the transfer still completes and done0 pulses once. No second transfer is issued.
